// File: rtl/alu_serial_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   - alu_ctl operation codes
//   - 1-bit slice op encodings (AND / OR / ADD / LESS)
//   - sequencer state encoding (IDLE / RUN / FIX / DONE)
//   - decode structure and the alu_ctl decode function
// ---------------------------------------------------------------------------
package alu_serial_ctrl_pkg;

    // alu_ctl operation codes
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    // Slice operation select
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic       ainvert;
        logic       binvert;
        logic [1:0] op;
        logic       legal;
    } decode_t;

    // Translate an alu_ctl code into slice controls. Illegal codes run as a
    // harmless AND and are flagged so the result can be forced to zero.
    function automatic decode_t decode_ctl(input logic [3:0] ctl);
        decode_t d;
        d.ainvert = 1'b0;
        d.binvert = 1'b0;
        d.op      = OP_AND;
        d.legal   = 1'b1;
        case (ctl)
            CTL_AND: d.op = OP_AND;
            CTL_OR:  d.op = OP_OR;
            CTL_ADD: d.op = OP_ADD;
            CTL_SUB: begin
                d.binvert = 1'b1;
                d.op      = OP_ADD;
            end
            CTL_SLT: begin
                d.binvert = 1'b1;
                d.op      = OP_LESS;
            end
            CTL_NOR: begin
                d.ainvert = 1'b1;
                d.binvert = 1'b1;
                d.op      = OP_AND;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// ---------------------------------------------------------------------------
// alu_serial_slice
// Combinational 1-bit ALU slice. The carry-in is used exactly as given; the
// sequencer owns carry initialisation and feedback.
// Ports:
//   a, b             operand bits
//   ainvert, binvert invert the corresponding operand bit before use
//   c_in             carry-in
//   less             value returned for the LESS op
//   op               OP_AND / OP_OR / OP_ADD / OP_LESS
//   result           selected slice output
//   c_out            carry-out of the full adder
//   sum              full-adder sum (used by the caller for SLT at the MSB)
// ---------------------------------------------------------------------------
module alu_serial_slice
    import alu_serial_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       c_in,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       c_out,
    output logic       sum
);

    logic a_s;
    logic b_s;

    // Operand conditioning, full adder and result select
    always_comb begin
        a_s   = a ^ ainvert;
        b_s   = b ^ binvert;
        sum   = a_s ^ b_s ^ c_in;
        c_out = (a_s & b_s) | (a_s & c_in) | (b_s & c_in);
        case (op)
            OP_AND:  result = a_s & b_s;
            OP_OR:   result = a_s | b_s;
            OP_ADD:  result = sum;
            OP_LESS: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
// Bit-serial ALU sequencer. Accepts an operation on a valid/ready handshake,
// steps a 1-bit slice LSB-first (one bit per clock, carry fed back), resolves
// SLT/overflow/zero in a single fix-up cycle, then presents the result on a
// valid/ready output handshake.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  operation request handshake (ready only in IDLE)
//   a, b, alu_ctl            operands and operation, sampled on accept
//   result, zero, overflow   registered outputs, valid while done_valid=1
//   done_valid/done_ready    result handshake
// ---------------------------------------------------------------------------
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    decode_t          dec_q, dec_d;
    logic             carry_q, carry_d;
    logic             ovf_msb_q, ovf_msb_d;
    logic             set_msb_q, set_msb_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             done_valid_q, done_valid_d;

    decode_t          dec_in_s;
    logic             last_bit_s;
    logic             slice_result_s;
    logic             slice_c_out_s;
    logic             slice_sum_s;
    logic             msb_ovf_s;
    logic [WIDTH-1:0] final_result_s;

    assign dec_in_s   = decode_ctl(alu_ctl);
    assign last_bit_s = (cnt_q == CNT_W'(WIDTH - 1));
    assign msb_ovf_s  = carry_q ^ slice_c_out_s;

    alu_serial_slice u_slice (
        .a       (a_q[cnt_q]),
        .b       (b_q[cnt_q]),
        .ainvert (dec_q.ainvert),
        .binvert (dec_q.binvert),
        .c_in    (carry_q),
        .less    (1'b0),
        .op      (dec_q.op),
        .result  (slice_result_s),
        .c_out   (slice_c_out_s),
        .sum     (slice_sum_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) state_d = ST_RUN;
                else             state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (last_bit_s) state_d = ST_FIX;
                else            state_d = ST_RUN;
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                if (done_ready) state_d = ST_IDLE;
                else            state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; ready is forced low while reset is held
    always_comb begin
        start_ready = (state_q == ST_IDLE) && rst_n;
        result      = result_q;
        zero        = zero_q;
        overflow    = overflow_q;
        done_valid  = done_valid_q;
    end

    // Final result: illegal codes give zero, SLT keeps only the set bit
    always_comb begin
        final_result_s = result_q;
        if (!dec_q.legal) begin
            final_result_s = {WIDTH{1'b0}};
        end else if (dec_q.op == OP_LESS) begin
            final_result_s = {{(WIDTH-1){1'b0}}, set_msb_q};
        end else begin
            final_result_s = result_q;
        end
    end

    // Datapath next values
    always_comb begin
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        dec_d        = dec_q;
        carry_d      = carry_q;
        ovf_msb_d    = ovf_msb_q;
        set_msb_d    = set_msb_q;
        zero_d       = zero_q;
        overflow_d   = overflow_q;
        done_valid_d = done_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    dec_d   = dec_in_s;
                    cnt_d   = {CNT_W{1'b0}};
                    // Binvert doubles as the +1 of two's-complement negation
                    carry_d = dec_in_s.binvert;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN: begin
                result_d[cnt_q] = slice_result_s;
                carry_d         = slice_c_out_s;
                if (last_bit_s) begin
                    ovf_msb_d = msb_ovf_s;
                    // True sign of a-b even when the subtraction overflows
                    set_msb_d = slice_sum_s ^ msb_ovf_s;
                    cnt_d     = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                result_d     = final_result_s;
                zero_d       = (final_result_s == {WIDTH{1'b0}});
                overflow_d   = dec_q.legal && (dec_q.op == OP_ADD) && ovf_msb_q;
                done_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (done_ready) done_valid_d = 1'b0;
                else            done_valid_d = 1'b1;
            end
            default: begin
                cnt_d        = {CNT_W{1'b0}};
                done_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= {CNT_W{1'b0}};
            a_q           <= {WIDTH{1'b0}};
            b_q           <= {WIDTH{1'b0}};
            result_q      <= {WIDTH{1'b0}};
            dec_q.ainvert <= 1'b0;
            dec_q.binvert <= 1'b0;
            dec_q.op      <= OP_AND;
            dec_q.legal   <= 1'b1;
            carry_q       <= 1'b0;
            ovf_msb_q     <= 1'b0;
            set_msb_q     <= 1'b0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            done_valid_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            result_q      <= result_d;
            dec_q         <= dec_d;
            carry_q       <= carry_d;
            ovf_msb_q     <= ovf_msb_d;
            set_msb_q     <= set_msb_d;
            zero_q        <= zero_d;
            overflow_q    <= overflow_d;
            done_valid_q  <= done_valid_d;
        end
    end

endmodule
